// File: rtl/cache_bus_arbiter_if.sv
// Bus bundle for cache_bus_arbiter: two core request ports, the shared
// memory port and status/snoop outputs. The "master" modport is the arbiter's
// view (it masters the memory bus). The "slave" modport is the environment's
// view (cores and memory).
// Optional feature macro: ARB_SNOOP_EN adds the write-invalidate snoop signals.
interface cache_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
`ifdef ARB_SNOOP_EN
  logic              snoop_valid;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_src;
`endif

`ifdef ARB_SNOOP_EN
  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_ack, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy,
    output snoop_valid, snoop_addr, snoop_src
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_ack, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy,
    input  snoop_valid, snoop_addr, snoop_src
  );
`else
  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_ack, mem_rdata,
    output gnt0, gnt1, done0, done1, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_ack, mem_rdata,
    input  gnt0, gnt1, done0, done1, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, busy
  );
`endif
endinterface

// File: rtl/cache_bus_arbiter.sv
// Two-core round-robin arbiter for a single shared memory port.
// The flow is IDLE -> BUS -> RESP -> IDLE. Every output is registered.
// A core that loses contention stays pending and is served in the next IDLE cycle.
// Optional feature macro: ARB_SNOOP_EN. When it is defined, a write-invalidate
// pulse is emitted on the first BUS cycle of each write grant.
module cache_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                rst_n,
  cache_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
`ifdef ARB_SNOOP_EN
  logic              snoop_valid_q, snoop_valid_d;
  logic [ADDR_W-1:0] snoop_addr_q, snoop_addr_d;
  logic              snoop_src_q, snoop_src_d;
`endif

  // Winner in IDLE: a lone requester wins; under contention the core that
  // did not own the bus last time wins.
  logic winner;
  assign winner = (bus.req0 && bus.req1) ? ~last_owner_q : bus.req1;

  // Next-state and registered-output computation for the arbitration FSM
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef ARB_SNOOP_EN
    snoop_valid_d = 1'b0;
    snoop_addr_d  = snoop_addr_q;
    snoop_src_d   = snoop_src_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d      = BUS;
          last_owner_d = winner;
          gnt0_d       = ~winner;
          gnt1_d       = winner;
          mem_req_d    = 1'b1;
          mem_we_d     = winner ? bus.we1    : bus.we0;
          mem_addr_d   = winner ? bus.addr1  : bus.addr0;
          mem_wdata_d  = winner ? bus.wdata1 : bus.wdata0;
`ifdef ARB_SNOOP_EN
          snoop_valid_d = winner ? bus.we1 : bus.we0;
          snoop_addr_d  = winner ? bus.addr1 : bus.addr0;
          snoop_src_d   = winner;
`endif
        end
      end
      BUS: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          mem_req_d = 1'b0;
          rdata_d   = bus.mem_rdata;
          done0_d   = ~last_owner_q;
          done1_d   = last_owner_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
`ifdef ARB_SNOOP_EN
      snoop_valid_q <= 1'b0;
      snoop_addr_q  <= '0;
      snoop_src_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
`ifdef ARB_SNOOP_EN
      snoop_valid_q <= snoop_valid_d;
      snoop_addr_q  <= snoop_addr_d;
      snoop_src_q   <= snoop_src_d;
`endif
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
`ifdef ARB_SNOOP_EN
  assign bus.snoop_valid = snoop_valid_q;
  assign bus.snoop_addr  = snoop_addr_q;
  assign bus.snoop_src   = snoop_src_q;
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard testbench for cache_bus_arbiter.
// The directed tests push the expected completions, in order, into a queue.
// A monitor pops and compares an entry on every done pulse.
// A memory responder process acknowledges mem_req after a programmable delay.
module tb_cache_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic              core;
    logic [DATA_W-1:0] data;
    logic              chkData;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  exp_t sbQ[$];
  logic overlapSeen;

  // Memory responder controls
  logic              autoAck;
  int                ackDelay;
  logic              forceAck;
  logic [DATA_W-1:0] forceData;

  cache_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  cache_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents seen by the responder, also used to build expectations
  function automatic logic [DATA_W-1:0] memData(input logic [ADDR_W-1:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic core, input logic req, input logic we,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    if (core) begin
      bif.req1 = req; bif.we1 = we; bif.addr1 = addr; bif.wdata1 = wdata;
    end else begin
      bif.req0 = req; bif.we0 = we; bif.addr0 = addr; bif.wdata0 = wdata;
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitDone(input logic core, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((core ? bif.done1 : bif.done0) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(core ? "wait_done1" : "wait_done0", {63'd0, seen}, 64'd1);
  endtask

  // Memory responder: ack after ackDelay BUS cycles, or replay forced values
  initial begin
    int cnt;
    cnt = 0;
    bif.mem_ack   = 1'b0;
    bif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!autoAck) begin
        bif.mem_ack   = forceAck;
        bif.mem_rdata = forceData;
        cnt = 0;
      end else if (bif.mem_req === 1'b1) begin
        if (cnt == ackDelay) begin
          bif.mem_ack   = 1'b1;
          bif.mem_rdata = memData(bif.mem_addr);
          cnt = 0;
        end else begin
          bif.mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        bif.mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: every done pulse must match the oldest expected completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((bif.gnt0 === 1'b1) && (bif.gnt1 === 1'b1)) overlapSeen = 1'b1;
      if ((bif.done0 === 1'b1) || (bif.done1 === 1'b1)) begin
        checkOutput("done_exclusive", {63'd0, bif.done0 & bif.done1}, 64'd0);
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", {62'd0, bif.done1, bif.done0}, 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("done_core", {63'd0, bif.done1}, {63'd0, e.core});
          if (e.chkData) checkOutput("done_rdata", {32'd0, bif.rdata}, {32'd0, e.data});
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; passes = 0; overlapSeen = 1'b0;
    autoAck = 1'b1; ackDelay = 0; forceAck = 1'b0; forceData = '0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state
    applyReset();
    checkOutput("reset_ctrl", {56'd0, bif.gnt0, bif.gnt1, bif.done0, bif.done1,
                bif.mem_req, bif.mem_we, bif.busy, 1'b0}, 64'd0);
    checkOutput("reset_addr_data", {bif.mem_addr, bif.mem_wdata}, 64'd0);
    checkOutput("reset_rdata", {32'd0, bif.rdata}, 64'd0);
`ifdef ARB_SNOOP_EN
    checkOutput("reset_snoop", {31'd0, bif.snoop_valid, bif.snoop_addr[30:0], bif.snoop_src},
                64'd0);
`endif

    // Single read from core 0, ack on first BUS cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, '0);
    sbQ.push_back('{core: 1'b0, data: 32'hDEADBEEF, chkData: 1'b1});
    tick();
    checkOutput("t1_grant", {60'd0, bif.gnt0, bif.gnt1, bif.mem_req, bif.busy}, 64'b1011);
    checkOutput("t1_mem_addr", {32'd0, bif.mem_addr}, 64'h100);
`ifdef ARB_SNOOP_EN
    checkOutput("t1_no_snoop_on_read", {63'd0, bif.snoop_valid}, 64'd0);
`endif
    tick();
    checkOutput("t1_done", {61'd0, bif.done0, bif.gnt0, bif.mem_req}, 64'b100);
    checkOutput("t1_rdata", {32'd0, bif.rdata}, 64'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h100, '0);
    tick();
    checkOutput("t1_idle", {62'd0, bif.busy, bif.done0}, 64'd0);
    checkOutput("t1_rdata_hold", {32'd0, bif.rdata}, 64'hDEADBEEF);

    // Simultaneous held requests after reset: 0, 1, 0 alternation
    applyReset();
    sbQ.push_back('{core: 1'b0, data: memData(32'h10), chkData: 1'b1});
    sbQ.push_back('{core: 1'b1, data: memData(32'h20), chkData: 1'b1});
    sbQ.push_back('{core: 1'b0, data: memData(32'h10), chkData: 1'b1});
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, '0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, '0);
    tick();
    checkOutput("t2_first_grant", {62'd0, bif.gnt0, bif.gnt1}, 64'b10);
    waitDone(1'b0, 10);
    waitDone(1'b1, 10);
    waitDone(1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h10, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h20, '0);
    tick();

    // Core 1 read with ack delayed 5 cycles
    ackDelay = 5;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000, '0);
    sbQ.push_back('{core: 1'b1, data: memData(32'h3000), chkData: 1'b1});
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("t3_stable_%0d", i),
                  {29'd0, bif.gnt0, bif.gnt1, bif.mem_req, bif.mem_addr},
                  {29'd0, 3'b011, 32'h3000});
    end
    tick();
    checkOutput("t3_done1", {62'd0, bif.done1, bif.mem_req}, 64'b10);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h3000, '0);
    ackDelay = 0;
    tick();

    // Reset during BUS abandons the transaction, a late ack is ignored
    autoAck = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h400, 32'h1234);
    tick();
    checkOutput("t4_grant", {63'd0, bif.gnt0}, 64'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("t4_reset_ctrl", {57'd0, bif.gnt0, bif.gnt1, bif.done0, bif.done1,
                bif.mem_req, bif.mem_we, bif.busy}, 64'd0);
    checkOutput("t4_reset_bus", {bif.mem_addr, bif.mem_wdata}, 64'd0);
    rst_n = 1'b1;
    forceAck = 1'b1;
    forceData = 32'h0BAD;
    tick();
    tick();
    checkOutput("t4_ignored_ack", {61'd0, bif.done0, bif.done1, bif.busy}, 64'd0);
    checkOutput("t4_rdata_zero", {32'd0, bif.rdata}, 64'd0);
    forceAck = 1'b0;
    tick();
    autoAck = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h500, '0);
    sbQ.push_back('{core: 1'b0, data: memData(32'h500), chkData: 1'b1});
    tick();
    checkOutput("t4_regrant", {62'd0, bif.gnt0, bif.gnt1}, 64'b10);
    waitDone(1'b0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h500, '0);
    tick();

    // Core 1 write, one BUS wait cycle
    ackDelay = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h2000, 32'hA5A5A5A5);
    sbQ.push_back('{core: 1'b1, data: '0, chkData: 1'b0});
    tick();
    checkOutput("t5_write_bus", {30'd0, bif.gnt1, bif.mem_we, bif.mem_wdata},
                {30'd0, 2'b11, 32'hA5A5A5A5});
`ifdef ARB_SNOOP_EN
    checkOutput("t5_snoop", {30'd0, bif.snoop_valid, bif.snoop_src, bif.snoop_addr},
                {30'd0, 2'b11, 32'h2000});
`endif
    tick();
    checkOutput("t5_still_bus", {62'd0, bif.gnt1, bif.mem_req}, 64'b11);
`ifdef ARB_SNOOP_EN
    checkOutput("t5_snoop_one_cycle", {63'd0, bif.snoop_valid}, 64'd0);
`endif
    waitDone(1'b1, 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h2000, '0);
    ackDelay = 0;
    tick();
    tick();

    checkOutput("gnt_overlap", {63'd0, overlapSeen}, 64'd0);
    checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req0 / req1  in  1  core 0 / core 1 cache requests a memory transaction.
REQ-007 we0 / we1  in  1  transaction is a write (1) or a read (0).
REQ-008 addr0 / addr1  in  ADDR_W  transaction address.
REQ-009 wdata0 / wdata1  in  DATA_W  write data.
REQ-010 gnt0 / gnt1  out  1  requester owns the memory bus.
REQ-011 done0 / done1  out  1  one-cycle transaction-complete pulse.
REQ-012 rdata  out  DATA_W  read data, shared, valid while donex=1.
REQ-013 mem_req  out  1  memory request.
REQ-014 mem_we  out  1  memory write.
REQ-015 mem_addr  out  ADDR_W  memory address.
REQ-016 mem_wdata  out  DATA_W  memory write data.
REQ-017 mem_ack  in  1  memory completed the current request.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
REQ-019 busy  out  1  state is not IDLE.
REQ-020 snoop_valid  out  1  write-invalidate broadcast, present only under ARB_SNOOP_EN.
REQ-021 snoop_addr  out  ADDR_W  invalidate address, present only under ARB_SNOOP_EN.
REQ-022 snoop_src  out  1  writing core id, present only under ARB_SNOOP_EN.

Function
REQ-023 All outputs SHALL be registered.
REQ-024 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-025 In IDLE the block SHALL sample req0/req1 only; mem_ack in IDLE SHALL be ignored.
REQ-026 In IDLE with any reqx=1, the FSM SHALL go to BUS next cycle.
- The winner's we/addr/wdata are latched into mem_we/mem_addr/mem_wdata.
- gntx=1 and mem_req=1 hold throughout BUS.
REQ-027 Arbitration SHALL be round-robin on a last_owner bit.
- Single requester: granted.
- Both requesting: the core not equal to last_owner wins.
- last_owner updates on entry to BUS.
REQ-028 In BUS, mem_ack=1 SHALL move the FSM to RESP.
- mem_rdata is captured into rdata.
- mem_req and gntx deassert in the next cycle.
REQ-029 In BUS without mem_ack, the FSM SHALL remain in BUS indefinitely with all bus outputs stable.
REQ-030 In RESP the block SHALL pulse donex=1 for the owner for exactly one cycle, then return to IDLE.
REQ-031 Minimum latency SHALL be 3 cycles (req at N, BUS at N+1 with ack at N+1, done at N+2), with the next grant no earlier than N+4.
REQ-032 Requesters SHALL hold reqx and their fields stable until donex; reqx still high in the IDLE cycle after RESP SHALL start a new transaction.
REQ-033 A loser's request SHALL stay pending without a grant; it is served in the next IDLE cycle.
REQ-034 rdata SHALL hold its value after RESP until the next capture; it is undefined for writes.
REQ-035 gnt0 and gnt1 SHALL never both be 1.

Reset
REQ-036 With rst_n=0 at a rising edge, the block SHALL enter IDLE with last_owner=1, so core 0 wins the first contention.
REQ-037 With rst_n=0 at a rising edge, all outputs, including rdata and the snoop outputs, SHALL become 0.
REQ-038 Reset during BUS or RESP SHALL abandon the transaction without a done pulse; a later mem_ack is ignored.

Configuration
REQ-039 With ARB_SNOOP_EN defined, snoop_valid SHALL pulse 1 for exactly the first BUS cycle of each write grant, with snoop_addr = the latched address and snoop_src = the owner.
REQ-040 Without ARB_SNOOP_EN, the snoop ports SHALL be absent and arbitration timing SHALL be identical.

Verification
REQ-041 Reset, then req0=1, we0=0, addr0=0x100, mem_ack at first BUS cycle with mem_rdata=0xDEADBEEF -> gnt0 at N+1, done0 and rdata=0xDEADBEEF at N+2.
REQ-042 req0 and req1 simultaneous after reset, held -> core 0 served first, then core 1, then core 0 (alternation); gnt0 and gnt1 never overlap.
REQ-043 Grant core 1, mem_ack delayed 5 cycles -> mem_req, gnt1 and mem_addr stable for 6 cycles; done1 in the cycle after ack.
REQ-044 rst_n=0 for one cycle during BUS -> all outputs 0; a mem_ack one cycle later -> no done pulse; next req0 granted normally.
REQ-045 ARB_SNOOP_EN defined, core 1 write to addr1=0x2000 -> snoop_valid=1 for one cycle with snoop_addr=0x2000 and snoop_src=1; a read -> no snoop pulse.
